arb_rr16_ctrl: RTL and testbench



---
 rtl/arb_pkg.sv | 34 +++
 rtl/arb_gnt_dec.sv | 14 +
 rtl/arb_rr16_ctrl.sv | 103 ++++++++++
 tb/tb_arb_rr16_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 16-way round-robin arbiter.
// Holds the FSM state enum, the fixed requester geometry, and the rotating
// priority search used to pick a winner from the pointer position upward.
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // First set request bit at or above ptr, wrapping from 15 to 0.
    // The returned value is only meaningful when req is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            // 4-bit addition wraps naturally modulo 16
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/arb_gnt_dec.sv
// 4-to-16 one-hot decoder with enable; drives the arbiter grant lines.
// Purely combinational, zero latency; no flow control.
// Ports: idx_i (index), en_i (enable), dec_o (one-hot, all zero when en_i=0).
module arb_gnt_dec
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] dec_o
);

    assign dec_o = en_i ? (N_REQ'(1) << idx_i) : '0;

endmodule

// File: rtl/arb_rr16_ctrl.sv
// Round-robin arbiter granting one shared resource to one of 16 requesters.
// Latency: req sampled at edge N gives a registered grant after edge N; one idle turnaround between grants.
// Backpressure: owner holds the grant until done, request withdrawal, or the hold timeout.
// Ports: clk/rst_n (async active-low); req[15:0], done in; gnt[15:0] one-hot,
//        gnt_idx, gnt_vld, busy, timeout_pulse out. All outputs come from registers.
module arb_rr16_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             busy,
    output logic             timeout_pulse
);

    // Counter must reach MAX_HOLD-1; keep at least one bit when timeout is disabled.
    localparam int              HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    logic owner_req;
    logic hold_expired;
    logic release_now;

    assign owner_req    = req[gnt_idx_q];
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign release_now  = done | ~owner_req | hold_expired;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = BUSY;
                    gnt_idx_d  = rr_pick(req, ptr_q);
                    hold_cnt_d = '0;
                end
            end
            BUSY: begin
                if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
                if (release_now) begin
                    state_d   = IDLE;
                    ptr_d     = gnt_idx_q + IDX_W'(1);
                    // A timeout only counts when nothing else released the grant.
                    timeout_d = hold_expired & ~done & owner_req;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: derived from registers only, so async reset clears them at once
    always_comb begin
        busy          = (state_q == BUSY);
        gnt_vld       = (state_q == BUSY);
        gnt_idx       = gnt_idx_q;
        timeout_pulse = timeout_q;
    end

    arb_gnt_dec u_gnt_dec (
        .idx_i (gnt_idx_q),
        .en_i  (state_q == BUSY),
        .dec_o (gnt)
    );

endmodule

// File: tb/tb_arb_rr16_ctrl.sv
module tb_arb_rr16_ctrl;

    localparam int TB_HOLD = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
    logic        busy;
    logic        timeout_pulse;

    int total;
    int bad;

    // Reference model state
    bit m_act;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic [15:0] gnt;
        logic [3:0]  idx;
        logic        vld;
        logic        to;
    } vec_t;

    vec_t tbl[30];

    arb_rr16_ctrl #(.MAX_HOLD(TB_HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .gnt_idx       (gnt_idx),
        .gnt_vld       (gnt_vld),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_act   = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 0;
    endtask

    // One clock edge of the arbiter's rules, using held-cycle counting.
    task automatic model_edge(input logic [15:0] r, input logic d);
        if (!m_act) begin
            m_to = 0;
            if (r != 16'h0) begin
                for (int k = 0; k < 16; k++) begin
                    int c;
                    c = (m_ptr + k) % 16;
                    if (r[c]) begin
                        m_owner = c;
                        m_act   = 1;
                        m_held  = 1;
                        break;
                    end
                end
            end
        end else begin
            bit tmo;
            tmo = (TB_HOLD != 0) && (m_held == TB_HOLD);
            if (d || !r[m_owner] || tmo) begin
                m_act = 0;
                m_ptr = (m_owner + 1) % 16;
                m_to  = tmo && !d && r[m_owner];
            end else begin
                m_held++;
                m_to = 0;
            end
        end
    endtask

    task automatic step(input logic [15:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic check_model(string tag);
        logic [15:0] eg;
        eg = m_act ? (16'h1 << m_owner) : 16'h0;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".idx"}, 32'(gnt_idx), 32'(m_owner));
        chk({tag, ".vld"}, 32'(gnt_vld), 32'(m_act));
        chk({tag, ".busy"}, 32'(busy), 32'(m_act));
        chk({tag, ".to"}, 32'(timeout_pulse), 32'(m_to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.idx", 32'(gnt_idx), 32'h0);
        chk("rst.vld", 32'(gnt_vld), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.to", 32'(timeout_pulse), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] cur_req;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();

        //            req       done  gnt       idx    vld   to
        tbl[0]  = '{16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        tbl[1]  = '{16'h0001, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[2]  = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[3]  = '{16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        tbl[4]  = '{16'h0010, 1'b1, 16'h0000, 4'd4,  1'b0, 1'b0};
        tbl[5]  = '{16'h0011, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        tbl[6]  = '{16'h0011, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[7]  = '{16'h0011, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        tbl[8]  = '{16'h0011, 1'b1, 16'h0000, 4'd4,  1'b0, 1'b0};
        tbl[9]  = '{16'h0800, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[10] = '{16'h0800, 1'b1, 16'h0000, 4'd11, 1'b0, 1'b0};
        tbl[11] = '{16'h0808, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b0};
        tbl[12] = '{16'h0808, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b0};
        tbl[13] = '{16'h0808, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b0};
        tbl[14] = '{16'h0808, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b0};
        tbl[15] = '{16'h0808, 1'b0, 16'h0000, 4'd3,  1'b0, 1'b1};
        tbl[16] = '{16'h0808, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[17] = '{16'h0808, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[18] = '{16'h0808, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[19] = '{16'h0808, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[20] = '{16'h0808, 1'b1, 16'h0000, 4'd11, 1'b0, 1'b0};
        tbl[21] = '{16'h0808, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b0};
        tbl[22] = '{16'h0800, 1'b0, 16'h0000, 4'd3,  1'b0, 1'b0};
        tbl[23] = '{16'h0800, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[24] = '{16'h0800, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[25] = '{16'h0800, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[26] = '{16'h0800, 1'b0, 16'h0800, 4'd11, 1'b1, 1'b0};
        tbl[27] = '{16'h0000, 1'b0, 16'h0000, 4'd11, 1'b0, 1'b0};
        tbl[28] = '{16'h0000, 1'b1, 16'h0000, 4'd11, 1'b0, 1'b0};
        tbl[29] = '{16'h0001, 1'b1, 16'h0001, 4'd0,  1'b1, 1'b0};

        // Directed table from reset
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(tbl[i].req, tbl[i].done);
            chk($sformatf("tbl%0d.gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d.idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
            chk($sformatf("tbl%0d.vld", i), 32'(gnt_vld), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d.to", i), 32'(timeout_pulse), 32'(tbl[i].to));
        end

        // Full rotation with all requesters active, done on the 2nd busy cycle
        do_reset();
        for (int g = 0; g < 17; g++) begin
            step(16'hFFFF, 1'b0);
            chk($sformatf("rot%0d.idx", g), 32'(gnt_idx), 32'(g % 16));
            chk($sformatf("rot%0d.gnt", g), 32'(gnt), 32'(16'h1 << (g % 16)));
            step(16'hFFFF, 1'b0);
            check_model($sformatf("rot%0d.c2", g));
            step(16'hFFFF, 1'b1);
            chk($sformatf("rot%0d.rel", g), 32'(gnt_vld), 32'h0);
        end

        // Asynchronous reset in the middle of a grant
        do_reset();
        step(16'h0040, 1'b0);
        chk("mid.pre_vld", 32'(gnt_vld), 32'h1);
        chk("mid.pre_idx", 32'(gnt_idx), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.gnt", 32'(gnt), 32'h0);
        chk("mid.vld", 32'(gnt_vld), 32'h0);
        chk("mid.busy", 32'(busy), 32'h0);
        chk("mid.idx", 32'(gnt_idx), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(16'h0080, 1'b0);
        chk("post.idx", 32'(gnt_idx), 32'h7);
        chk("post.gnt", 32'(gnt), 32'h0080);
        step(16'h0080, 1'b1);
        check_model("post.rel");

        // Randomized traffic against the reference model
        do_reset();
        cur_req = 16'h0;
        for (int n = 0; n < 1500; n++) begin
            logic d;
            case ($urandom_range(0, 15))
                0, 1:    cur_req = 16'($urandom);
                2:       cur_req = 16'h0;
                3:       cur_req = 16'h1 << $urandom_range(0, 15);
                4:       cur_req = cur_req ^ (16'h1 << $urandom_range(0, 15));
                default: cur_req = cur_req;
            endcase
            d = ($urandom_range(0, 7) == 0);
            step(cur_req, d);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
